// File: rtl/quadrature_pkg.sv
// Shared types and constants for the quadrature step decoder.
package quadrature_pkg;

  typedef logic [1:0] phase_t;

  // Gray-code positions of the {A,B} pair, in up-count order.
  localparam phase_t PHASE_00 = 2'b00;
  localparam phase_t PHASE_01 = 2'b01;
  localparam phase_t PHASE_11 = 2'b11;
  localparam phase_t PHASE_10 = 2'b10;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic {
    StFill,
    StTrack
  } state_e;

  // Phase that follows p when moving one step in the up direction.
  function automatic phase_t phase_step_up(input phase_t p);
    phase_t nxt;
    unique case (p)
      PHASE_00: nxt = PHASE_01;
      PHASE_01: nxt = PHASE_11;
      PHASE_11: nxt = PHASE_10;
      default:  nxt = PHASE_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quadrature_input_filter.sv
// One quadrature channel: synchronizer chain followed by a stability filter.
module quadrature_input_filter #(
  parameter int unsigned SYNC_DEPTH    = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_i,
  input  logic track_i,
  input  logic load_i,
  output logic filtered_o,
  output logic filtered_next_o
);

  localparam int unsigned CntW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(FILTER_CYCLES - 1);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  sync_out;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  filt_q, filt_d;

  assign sync_out = sync_q[SYNC_DEPTH-1];

  // Synchronizer shift chain; bit 0 faces the pin.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], raw_i};
    end
  end

  // Stability counter and filtered value next state.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (load_i) begin
      // Take the value the last sync stage captures on this same edge, so the
      // load sees the pin level rather than the reset value still in the chain.
      filt_d = sync_q[SYNC_DEPTH-2];
      cnt_d  = '0;
    end else if (!track_i) begin
      cnt_d = '0;
    end else if (sync_out != filt_q) begin
      if (cnt_q == LastCnt) begin
        filt_d = ~filt_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Filter state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filtered_o      = filt_q;
  assign filtered_next_o = filt_d;

endmodule

// File: rtl/quadrature_step_decoder.sv
// Quadrature A/B decoder producing single-cycle step pulses and a direction level.
module quadrature_step_decoder
  import quadrature_pkg::*;
#(
  parameter int unsigned SYNC_DEPTH        = 2,
  parameter int unsigned FILTER_CYCLES     = 4,
  parameter int unsigned ERROR_COUNT_WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         phase_a,
  input  logic                         phase_b,
  input  logic                         enable,
  input  logic                         clear_error,
  output logic                         run,
  output logic                         up_down,
  output logic                         error,
  output logic [ERROR_COUNT_WIDTH-1:0] error_count,
  output logic [1:0]                   phase_state
);

  localparam int unsigned FillW = $clog2(SYNC_DEPTH);
  localparam logic [FillW-1:0] LastFill = FillW'(SYNC_DEPTH - 1);

  state_e                       state_q, state_d;
  logic [FillW-1:0]             fill_cnt_q, fill_cnt_d;
  logic                         load_direct, track;
  phase_t                       filt_ab, filt_next, prev_q, prev_d, changed;
  logic                         step_legal, step_illegal;
  logic                         run_q, run_d, up_down_q, up_down_d, error_q, error_d;
  logic [ERROR_COUNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  quadrature_input_filter #(
    .SYNC_DEPTH    (SYNC_DEPTH),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_filter_a (
    .clock           (clock),
    .reset_n         (reset_n),
    .raw_i           (phase_a),
    .track_i         (track),
    .load_i          (load_direct),
    .filtered_o      (filt_ab[1]),
    .filtered_next_o (filt_next[1])
  );

  quadrature_input_filter #(
    .SYNC_DEPTH    (SYNC_DEPTH),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_filter_b (
    .clock           (clock),
    .reset_n         (reset_n),
    .raw_i           (phase_b),
    .track_i         (track),
    .load_i          (load_direct),
    .filtered_o      (filt_ab[0]),
    .filtered_next_o (filt_next[0])
  );

  // FSM next state: wait for the synchronizers to fill, then track.
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    load_direct = 1'b0;
    track       = 1'b0;
    unique case (state_q)
      StFill: begin
        if (fill_cnt_q == LastFill) begin
          load_direct = 1'b1;
          fill_cnt_d  = '0;
          state_d     = StTrack;
        end else begin
          fill_cnt_d = fill_cnt_q + 1'b1;
        end
      end
      StTrack: track = 1'b1;
      default: state_d = StFill;
    endcase
  end

  // Step decode from the previous vs. current filtered phase, plus error tally.
  always_comb begin
    changed      = prev_q ^ filt_ab;
    step_legal   = track && (changed == 2'b01 || changed == 2'b10);
    step_illegal = track && (changed == 2'b11);
    // The direct load makes prev match filtered, so leaving FILL is not a step.
    prev_d       = load_direct ? filt_next : filt_ab;
    run_d        = step_legal && enable;
    up_down_d    = up_down_q;
    error_d      = error_q;
    err_cnt_d    = err_cnt_q;
    if (run_d) begin
      up_down_d = (filt_ab == phase_step_up(prev_q)) ? DIR_UP : DIR_DOWN;
    end
    if (step_illegal && enable) begin
      error_d = 1'b1;
      // A same-cycle clear still wipes history; the new event counts as one.
      if (clear_error) begin
        err_cnt_d = ERROR_COUNT_WIDTH'(1);
      end else if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end else if (clear_error) begin
      error_d   = 1'b0;
      err_cnt_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StFill;
      fill_cnt_q <= '0;
      prev_q     <= PHASE_00;
      run_q      <= 1'b0;
      up_down_q  <= DIR_UP;
      error_q    <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      prev_q     <= prev_d;
      run_q      <= run_d;
      up_down_q  <= up_down_d;
      error_q    <= error_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign run         = run_q;
  assign up_down     = up_down_q;
  assign error       = error_q;
  assign error_count = err_cnt_q;
  assign phase_state = filt_ab;

endmodule
